// File: rtl/adc_sample_sequencer_if.sv
// Control, ADC-side and output-stream signals of the ADC sample sequencer.
// master = sequencer side, slave = environment (ADC controller, consumer, CSRs).
interface adc_sample_sequencer_if #(
  parameter int RESOLUTION = 8,
  parameter int PERIOD_W   = 16
);
  logic                  en;
  logic [PERIOD_W-1:0]   period;
  logic                  clr;
  logic                  adc_start;
  logic                  adc_rdy;
  logic [RESOLUTION-1:0] adc_result;
  logic [RESOLUTION-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  overrun;
  logic                  skip;

  modport master (
    input  en, period, clr, adc_rdy, adc_result, ready,
    output adc_start, data, valid, overrun, skip
  );

  modport slave (
    output en, period, clr, adc_rdy, adc_result, ready,
    input  adc_start, data, valid, overrun, skip
  );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Periodically starts the SAR ADC, captures each result, averages 2**AVG_LOG2 results
// and offers the mean on a one-entry valid/ready output register.
module adc_sample_sequencer #(
  parameter int RESOLUTION = 8,
  parameter int AVG_LOG2   = 2,
  parameter int PERIOD_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  adc_sample_sequencer_if.master bus
);
  localparam int ACC_W  = RESOLUTION + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam logic [SCNT_W-1:0] LAST = SCNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t                state;
  logic [PERIOD_W-1:0]   cnt, per_q, per_cur;
  logic                  tick, rdy_q, keep, capture, done;
  logic [ACC_W-1:0]      acc, sum;
  logic [SCNT_W-1:0]     scnt;
  logic [RESOLUTION-1:0] avg;

  // period_i only takes effect at the start of a period (cnt == 0)
  assign per_cur = (cnt == '0) ? bus.period : per_q;
  assign tick    = bus.en && (cnt == per_cur);

  // result is only valid in the first ready cycle; keep drops results of
  // conversions that saw en low at any point
  assign capture = (state == BUSY) && !rdy_q && bus.adc_rdy && keep && bus.en;
  assign sum     = acc + ACC_W'(bus.adc_result);
  assign done    = capture && (scnt == LAST);
  assign avg     = RESOLUTION'(sum >> AVG_LOG2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      per_q <= '0;
    end else begin
      if (cnt == '0) per_q <= bus.period;
      if (!bus.en || tick) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      bus.adc_start <= 1'b0;
      rdy_q         <= 1'b0;
      keep          <= 1'b0;
      bus.skip      <= 1'b0;
    end else begin
      rdy_q         <= bus.adc_rdy;
      bus.adc_start <= 1'b0;
      if (!bus.en)  keep     <= 1'b0;
      if (bus.clr)  bus.skip <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          if (bus.adc_rdy) begin
            state         <= START;
            bus.adc_start <= 1'b1;
            keep          <= 1'b1;
          end else begin
            bus.skip <= 1'b1;
          end
        end
        START: begin
          state <= BUSY;
          if (tick) bus.skip <= 1'b1;
        end
        BUSY: begin
          if (!rdy_q && bus.adc_rdy) state <= IDLE;
          if (tick) bus.skip <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc         <= '0;
      scnt        <= '0;
      bus.data    <= '0;
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (!bus.en) begin
        acc  <= '0;
        scnt <= '0;
      end else if (capture) begin
        if (done) begin
          acc  <= '0;
          scnt <= '0;
        end else begin
          acc  <= sum;
          scnt <= scnt + 1'b1;
        end
      end
      if (bus.clr) bus.overrun <= 1'b0;
      // a handshake in the completion cycle frees the slot for the new average
      if (done && bus.valid && !bus.ready) begin
        bus.overrun <= 1'b1;
      end else if (done) begin
        bus.data  <= avg;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: ADC controller model, cycle-stamp reference model,
// table-driven averaging vectors, directed corner sequences and a random phase.
module tb_adc_sample_sequencer;
  localparam int RES      = 8;
  localparam int AVG_LOG2 = 2;
  localparam int PW       = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_sample_sequencer_if #(.RESOLUTION(RES), .PERIOD_W(PW)) bus ();

  adc_sample_sequencer #(.RESOLUTION(RES), .AVG_LOG2(AVG_LOG2), .PERIOD_W(PW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC controller model ----------------
  logic [RES-1:0] res_q[$];
  int   adc_cnt   = 0;
  int   fresh_cnt = 0;
  logic adc_fresh;

  function automatic logic [RES-1:0] next_result();
    if (res_q.size() > 0) return res_q.pop_front();
    return RES'($urandom);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.adc_rdy    <= 1'b1;
      bus.adc_result <= '0;
      adc_cnt        <= 0;
      adc_fresh      <= 1'b0;
    end else begin
      adc_fresh      <= 1'b0;
      bus.adc_result <= '0;
      if (adc_cnt == 0) begin
        if (bus.adc_start) begin
          bus.adc_rdy <= 1'b0;
          adc_cnt     <= RES + 1;
        end
      end else begin
        adc_cnt <= adc_cnt - 1;
        if (adc_cnt == 1) begin
          bus.adc_rdy    <= 1'b1;
          adc_fresh      <= 1'b1;
          fresh_cnt      <= fresh_cnt + 1;
          bus.adc_result <= next_result();
        end
      end
    end
  end

  // ---------------- reference model (cycle stamps + sample queue) ----------------
  int cyc = 0, m_wrap = 0, m_per = 0, m_last_start = -1000, start_cnt = 0;
  bit m_ok = 0, m_full = 0, m_ovr = 0, m_skip = 0;
  logic [RES-1:0] m_data = '0;
  int m_samp[$];

  always @(negedge clk) begin : model
    bit tick, done, hs, idle;
    int sum;
    tick = 0; done = 0; hs = 0; idle = 0; sum = 0;
    if (!rst_n) begin
      m_wrap = cyc + 1; m_per = 0; m_last_start = -1000;
      m_ok = 0; m_full = 0; m_ovr = 0; m_skip = 0; m_data = '0;
      m_samp.delete();
    end else begin
      if (bus.adc_start) start_cnt++;
      chk("adc_start", bus.adc_start, cyc == m_last_start);
      chk("valid", bus.valid, m_full);
      if (m_full) chk("data", bus.data, m_data);
      chk("overrun", bus.overrun, m_ovr);
      chk("skip", bus.skip, m_skip);

      if (bus.en) begin
        if (cyc == m_wrap) m_per = int'(bus.period);
        if (cyc == m_wrap + m_per) begin tick = 1; m_wrap = cyc + 1; end
      end else begin
        m_wrap = cyc + 1;
      end
      // a conversion occupies the start cycle through its capture cycle
      idle = cyc > m_last_start + RES + 2;
      if (bus.clr) begin m_skip = 0; m_ovr = 0; end
      if (tick) begin
        if (idle && bus.adc_rdy) m_last_start = cyc + 1;
        else m_skip = 1;
      end
      if (cyc == m_last_start) m_ok = 1;
      if (!bus.en) begin m_ok = 0; m_samp.delete(); end
      if (adc_fresh && m_ok) begin
        m_samp.push_back(int'(bus.adc_result));
        if (m_samp.size() == (1 << AVG_LOG2)) begin
          foreach (m_samp[k]) sum += m_samp[k];
          m_samp.delete();
          done = 1;
        end
      end
      hs = m_full && bus.ready;
      if (done && m_full && !hs) m_ovr = 1;
      else if (done) begin m_data = RES'(sum >> AVG_LOG2); m_full = 1; end
      else if (hs) m_full = 0;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int                   period;
    logic [3:0][RES-1:0]  r;
    logic [RES-1:0]       avg;
  } vec_t;
  vec_t vt[6];

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n = 0; ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.valid) begin ok = 1; break; end
      n++;
    end
    chk("valid_timeout", ok, 1);
  endtask

  task automatic settle();
    repeat (RES + 8) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, f0;
    bit ok;
    vt[0] = '{period: 19, r: {8'hA5, 8'hA5, 8'hA5, 8'hA5}, avg: 8'hA5};
    vt[1] = '{period: 24, r: {8'd10, 8'd11, 8'd12, 8'd14}, avg: 8'd11};
    vt[2] = '{period: 30, r: {8'd0,  8'd0,  8'd0,  8'd0 }, avg: 8'd0};
    vt[3] = '{period: 22, r: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, avg: 8'hFF};
    vt[4] = '{period: 25, r: {8'hFF, 8'hFF, 8'hFF, 8'hFE}, avg: 8'hFE};
    vt[5] = '{period: 20, r: {8'd1,  8'd2,  8'd3,  8'd5 }, avg: 8'd2};

    rst_n = 1'b0; bus.en = 1'b0; bus.period = '0; bus.clr = 1'b0; bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_adc_start", bus.adc_start, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_skip", bus.skip, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // averaging vectors: latency from enable to valid and the mean itself
    for (int i = 0; i < 6; i++) begin
      settle();
      res_q.delete();
      for (int k = 0; k < 4; k++) res_q.push_back(vt[i].r[k]);
      bus.period = PW'(vt[i].period);
      bus.ready  = 1'b1;
      bus.en     = 1'b1;
      wait_valid(4 * (vt[i].period + 1) + 60, n, ok);
      chk("vec_latency", n, 4 * (vt[i].period + 1) + RES + 3);
      chk("vec_avg", bus.data, vt[i].avg);
      @(posedge clk); #1 bus.en = 1'b0;
    end

    // too-short period: every other tick is skipped
    settle();
    res_q.delete();
    bus.period = PW'(5);
    f0 = start_cnt;
    bus.en = 1'b1;
    repeat (72) @(posedge clk);
    #1 bus.en = 1'b0;
    settle();
    chk("short_starts", start_cnt - f0, 6);
    @(negedge clk);
    chk("short_skip_set", bus.skip, 1);
    @(posedge clk); #1 bus.clr = 1'b1;
    @(posedge clk); #1 bus.clr = 1'b0;
    @(negedge clk);
    chk("short_skip_clr", bus.skip, 0);

    // backpressure over three averages
    @(posedge clk); #1;
    res_q.delete();
    for (int k = 0; k < 4; k++) res_q.push_back(8'd40);
    for (int k = 0; k < 4; k++) res_q.push_back(8'd80);
    for (int k = 0; k < 4; k++) res_q.push_back(8'd120);
    bus.ready = 1'b0; bus.period = PW'(24);
    f0 = fresh_cnt;
    bus.en = 1'b1;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fresh_cnt - f0 >= 12) begin ok = 1; break; end
    end
    chk("bp_wait", ok, 1);
    @(negedge clk);
    chk("bp_data", bus.data, 40);
    chk("bp_valid", bus.valid, 1);
    chk("bp_overrun", bus.overrun, 1);
    @(posedge clk); #1 bus.en = 1'b0; bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_drain", bus.valid, 0);
    @(posedge clk); #1 bus.clr = 1'b1;
    @(posedge clk); #1 bus.clr = 1'b0;

    // enable dropped mid-conversion after two samples
    settle();
    res_q.delete();
    repeat (3) res_q.push_back(8'd200);
    bus.ready = 1'b0; bus.period = PW'(24);
    f0 = fresh_cnt;
    bus.en = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (fresh_cnt - f0 >= 2) begin ok = 1; break; end
    end
    chk("drop_wait2", ok, 1);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.adc_rdy) begin ok = 1; break; end
    end
    chk("drop_inflight", ok, 1);
    @(posedge clk); #1 bus.en = 1'b0;
    settle();
    @(negedge clk);
    chk("drop_no_out", bus.valid, 0);
    @(posedge clk); #1;
    res_q.delete();
    res_q.push_back(8'd100); res_q.push_back(8'd104);
    res_q.push_back(8'd108); res_q.push_back(8'd112);
    bus.en = 1'b1;
    wait_valid(4 * 25 + 60, n, ok);
    chk("drop_fresh_avg", bus.data, 106);

    // async reset while a conversion is in flight
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.adc_rdy) begin ok = 1; break; end
    end
    chk("rst_busy_wait", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_adc_start", bus.adc_start, 0);
    chk("arst_valid", bus.valid, 0);
    chk("arst_data", bus.data, 0);
    chk("arst_overrun", bus.overrun, 0);
    chk("arst_skip", bus.skip, 0);
    bus.period = PW'(9);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    ok = 0; n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.adc_start) begin ok = 1; break; end
      n++;
    end
    chk("arst_first_start_seen", ok, 1);
    chk("arst_first_start", n, 10);

    // random phase against the reference model
    @(posedge clk); #1 bus.ready = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      bus.ready = ($urandom_range(9) < 7);
      bus.clr   = ($urandom_range(49) == 0);
      if ($urandom_range(149) == 0) bus.en = !bus.en;
      if ($urandom_range(99) == 0)  bus.period = PW'($urandom_range(40));
    end
    bus.en = 1'b0; bus.clr = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
